control_alu_uart: RTL and testbench
===================================

Name: control_alu_uart

Overview:
- Sequencer between the UART receiver/transmitter pair and the combinational ALU.
- Collects three bytes from the receiver in order: operand 1, operand 2, opcode. Drives them as stable ALU inputs.
- Captures the ALU result, sign-extends it, and hands it to the transmitter with a start/done handshake.
- An inter-byte timeout discards incomplete commands so a lost byte cannot desynchronise the stream.

Parameters:
- CANT_BITS_DATO, 8, width of the UART data word.
- CANT_BUS_ENTRADA, 6, width of each ALU operand.
- CANT_BUS_SALIDA, 6, width of the ALU result.
- CANT_BITS_OPCODE, 4, width of the ALU opcode.
- TIMEOUT, 50000000, clock cycles allowed between bytes of one command; 0 disables the timeout.

Ports:
- i_clock  in  1  system clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_rx_data  in  CANT_BITS_DATO  byte from the UART receiver; valid only when i_rx_done=1.
- i_rx_done  in  1  one-cycle pulse: new byte on i_rx_data.
- i_tx_done  in  1  one-cycle pulse: transmitter finished the current byte.
- i_resultado_alu  in  CANT_BUS_SALIDA  signed ALU result (combinational from o_operando_1/2, o_opcode).
- o_operando_1  out  CANT_BUS_ENTRADA  registered ALU operand 1.
- o_operando_2  out  CANT_BUS_ENTRADA  registered ALU operand 2.
- o_opcode  out  CANT_BITS_OPCODE  registered ALU opcode.
- o_tx_data  out  CANT_BITS_DATO  byte to transmit; sign-extended result.
- o_tx_start  out  1  one-cycle pulse requesting transmission.
- o_error  out  1  one-cycle pulse on timeout abort.
- o_estado  out  3  current state encoding, for LEDs and debug.

Behaviour:
- Reset (asynchronous, active-high; immediate from any state, including mid-command or mid-transmission):
  - State returns to ESPERA_OP1.
  - o_operando_1, o_operando_2, o_opcode, o_tx_data = 0.
  - o_tx_start = 0, o_error = 0.
  - Timeout counter = 0.
- State encodings (o_estado): ESPERA_OP1=0, ESPERA_OP2=1, ESPERA_OPCODE=2, CALCULO=3, ENVIO=4, ESPERA_TX=5. Unused codes go to ESPERA_OP1.
- ESPERA_OP1:
  - On i_rx_done: o_operando_1 <= i_rx_data[CANT_BUS_ENTRADA-1:0], upper bits discarded.
  - Go to ESPERA_OP2.
  - No timeout in this state.
- ESPERA_OP2:
  - On i_rx_done: o_operando_2 <= low CANT_BUS_ENTRADA bits of the byte; go to ESPERA_OPCODE.
- ESPERA_OPCODE:
  - On i_rx_done: o_opcode <= i_rx_data[CANT_BITS_OPCODE-1:0]; go to CALCULO.
- CALCULO (exactly 1 cycle, inputs already stable):
  - o_tx_data <= i_resultado_alu sign-extended to CANT_BITS_DATO.
  - If CANT_BUS_SALIDA >= CANT_BITS_DATO, the low CANT_BITS_DATO bits are taken instead.
  - Go to ENVIO.
- ENVIO:
  - o_tx_start=1 for exactly this one cycle; go to ESPERA_TX.
- ESPERA_TX:
  - Hold o_tx_data.
  - On i_tx_done go to ESPERA_OP1. No timeout here.
- Operand and opcode registers hold their values until overwritten. The ALU output therefore stays valid after transmission.
- Latency: o_tx_start asserts 2 cycles after the cycle in which the opcode byte's i_rx_done is sampled.
- Timeout (ESPERA_OP2 and ESPERA_OPCODE only):
  - The counter clears on entry to either state and on every accepted byte, and increments each cycle otherwise.
  - When the counter reaches TIMEOUT-1 with no i_rx_done: o_error pulses 1 cycle, state goes to ESPERA_OP1, and registers keep their old values.
  - If i_rx_done and expiry coincide, the byte wins: it is accepted and there is no error.
  - Counter width: $clog2(TIMEOUT+1), minimum 1.
- i_rx_done in CALCULO, ENVIO or ESPERA_TX: the byte is dropped with no side effects.
- i_rx_done in the same cycle as i_tx_done in ESPERA_TX: the byte is dropped and the state goes to ESPERA_OP1.
- i_tx_done outside ESPERA_TX: ignored.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- ADD, TIMEOUT=100, ALU attached: rx bytes 0x05, 0x03, 0x08, 10 cycles apart.
  -> o_operando_1=5, o_operando_2=3, o_opcode=4'b1000.
  -> o_tx_data=0x08; single o_tx_start pulse 2 cycles after the third rx_done.
  -> After i_tx_done, o_estado=0.
- Signed SUB with width truncation: bytes 0xFE, 0x01, 0xFA.
  -> o_operando_1=6'b111110 (-2), o_opcode=4'b1010.
  -> Result -3, so o_tx_data=0xFD.
- Timeout: byte 0x05, then silence for 100 cycles.
  -> o_error pulses once in cycle 100 after entering ESPERA_OP2; state returns to ESPERA_OP1.
  -> A following command 0x01, 0x01, 0x08 yields o_tx_data=0x02.
- Boundary: second byte's rx_done lands exactly in the expiry cycle.
  -> Byte accepted, no o_error, state=ESPERA_OPCODE.
- Dropped bytes: pulse rx_done with 0x33 during ESPERA_TX, with and without a simultaneous i_tx_done.
  -> Operands unchanged, no extra o_tx_start, next command processed normally.
- Reset mid-command: assert i_reset asynchronously (between clock edges) after two bytes, and again in ESPERA_TX.
  -> Outputs 0 immediately, o_estado=0; a fresh 3-byte command completes correctly.

Source files
------------

// File: rtl/control_alu_uart_if.sv
// Signal bundle between the UART/ALU sequencer and its environment
// (UART receiver/transmitter pair plus the combinational ALU).
interface control_alu_uart_if #(
  parameter int CANT_BITS_DATO   = 8,
  parameter int CANT_BUS_ENTRADA = 6,
  parameter int CANT_BUS_SALIDA  = 6,
  parameter int CANT_BITS_OPCODE = 4
);
  logic [CANT_BITS_DATO-1:0]   rx_data;
  logic                        rx_done;
  logic                        tx_done;
  logic [CANT_BUS_SALIDA-1:0]  resultado_alu;
  logic [CANT_BUS_ENTRADA-1:0] operando_1;
  logic [CANT_BUS_ENTRADA-1:0] operando_2;
  logic [CANT_BITS_OPCODE-1:0] opcode;
  logic [CANT_BITS_DATO-1:0]   tx_data;
  logic                        tx_start;
  logic                        error;
  logic [2:0]                  estado;

  // The sequencer owns operands, opcode and transmit request
  modport master (
    input  rx_data, rx_done, tx_done, resultado_alu,
    output operando_1, operando_2, opcode, tx_data, tx_start, error, estado
  );

  modport slave (
    output rx_data, rx_done, tx_done, resultado_alu,
    input  operando_1, operando_2, opcode, tx_data, tx_start, error, estado
  );
endinterface

// File: rtl/control_alu_uart.sv
// Sequencer: gathers operand 1, operand 2 and opcode from the UART receiver,
// presents them to the ALU, then sends the sign-extended result to the transmitter.
module control_alu_uart #(
  parameter int CANT_BITS_DATO   = 8,
  parameter int CANT_BUS_ENTRADA = 6,
  parameter int CANT_BUS_SALIDA  = 6,
  parameter int CANT_BITS_OPCODE = 4,
  parameter int TIMEOUT          = 50000000
) (
  input logic clk,
  input logic rst,
  control_alu_uart_if.master bus
);

  localparam int CW_RAW = $clog2(TIMEOUT + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] CNT_MAX = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    ESPERA_OP1    = 3'd0,
    ESPERA_OP2    = 3'd1,
    ESPERA_OPCODE = 3'd2,
    CALCULO       = 3'd3,
    ENVIO         = 3'd4,
    ESPERA_TX     = 3'd5
  } state_t;

  state_t                      state;
  logic [CW-1:0]               cnt;
  logic [CANT_BUS_ENTRADA-1:0] operando_1;
  logic [CANT_BUS_ENTRADA-1:0] operando_2;
  logic [CANT_BITS_OPCODE-1:0] opcode;
  logic [CANT_BITS_DATO-1:0]   tx_data;
  logic                        tx_start;
  logic                        error;
  logic [CANT_BITS_DATO-1:0]   result_ext;
  logic                        expired;

  // A result at least as wide as the UART word is truncated, otherwise sign-extended
  generate
    if (CANT_BUS_SALIDA >= CANT_BITS_DATO) begin : g_trunc
      assign result_ext = bus.resultado_alu[CANT_BITS_DATO-1:0];
    end else begin : g_sext
      assign result_ext = {{(CANT_BITS_DATO-CANT_BUS_SALIDA){bus.resultado_alu[CANT_BUS_SALIDA-1]}},
                           bus.resultado_alu};
    end
  endgenerate

  assign expired = (TIMEOUT != 0) && (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ESPERA_OP1;
      cnt        <= '0;
      operando_1 <= '0;
      operando_2 <= '0;
      opcode     <= '0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      error      <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      error    <= 1'b0;
      case (state)
        ESPERA_OP1: begin
          cnt <= '0;
          if (bus.rx_done) begin
            operando_1 <= bus.rx_data[CANT_BUS_ENTRADA-1:0];
            state      <= ESPERA_OP2;
          end
        end
        // An arriving byte takes priority over a coinciding expiry
        ESPERA_OP2: begin
          if (bus.rx_done) begin
            operando_2 <= bus.rx_data[CANT_BUS_ENTRADA-1:0];
            cnt        <= '0;
            state      <= ESPERA_OPCODE;
          end else if (expired) begin
            error <= 1'b1;
            cnt   <= '0;
            state <= ESPERA_OP1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ESPERA_OPCODE: begin
          if (bus.rx_done) begin
            opcode <= bus.rx_data[CANT_BITS_OPCODE-1:0];
            cnt    <= '0;
            state  <= CALCULO;
          end else if (expired) begin
            error <= 1'b1;
            cnt   <= '0;
            state <= ESPERA_OP1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // tx_start is registered here so it is high exactly during ENVIO
        CALCULO: begin
          cnt      <= '0;
          tx_data  <= result_ext;
          tx_start <= 1'b1;
          state    <= ENVIO;
        end
        ENVIO: begin
          cnt   <= '0;
          state <= ESPERA_TX;
        end
        ESPERA_TX: begin
          cnt <= '0;
          if (bus.tx_done) begin
            state <= ESPERA_OP1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ESPERA_OP1;
        end
      endcase
    end
  end

  assign bus.operando_1 = operando_1;
  assign bus.operando_2 = operando_2;
  assign bus.opcode     = opcode;
  assign bus.tx_data    = tx_data;
  assign bus.tx_start   = tx_start;
  assign bus.error      = error;
  assign bus.estado     = state;

endmodule

// File: tb/tb_control_alu_uart.sv
// Directed bench for control_alu_uart with a small ALU attached; expected
// values are hand-computed per command.
module tb_control_alu_uart;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   start_count;
  int   err_pulses;
  int   starts_before;

  control_alu_uart_if #(
    .CANT_BITS_DATO(8), .CANT_BUS_ENTRADA(6), .CANT_BUS_SALIDA(6), .CANT_BITS_OPCODE(4)
  ) bus ();

  control_alu_uart #(
    .CANT_BITS_DATO(8), .CANT_BUS_ENTRADA(6), .CANT_BUS_SALIDA(6),
    .CANT_BITS_OPCODE(4), .TIMEOUT(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU stand-in driven by the sequencer's operand registers
  always_comb begin
    bus.resultado_alu = '0;
    case (bus.opcode)
      4'b1000: bus.resultado_alu = bus.operando_1 + bus.operando_2;
      4'b1010: bus.resultado_alu = bus.operando_1 - bus.operando_2;
      4'b1100: bus.resultado_alu = bus.operando_1 & bus.operando_2;
      4'b1101: bus.resultado_alu = bus.operando_1 | bus.operando_2;
      4'b1110: bus.resultado_alu = bus.operando_1 ^ bus.operando_2;
      default: bus.resultado_alu = '0;
    endcase
  end

  always @(negedge clk) begin
    if (bus.tx_start) start_count++;
    if (bus.error) err_pulses++;
  end

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [7:0] op1, input logic [7:0] op2,
                                input logic [7:0] opc);
    send_byte(op1);
    idle(10);
    send_byte(op2);
    idle(10);
    send_byte(opc);
  endtask

  // Called right after the opcode byte was sampled: CALCULO now, ENVIO next
  task automatic expect_tx(input string tag, input logic [7:0] exp_data);
    check_output({tag, " calc state"}, bus.estado, 3);
    check_output({tag, " start early"}, bus.tx_start, 0);
    @(negedge clk);
    check_output({tag, " envio state"}, bus.estado, 4);
    check_output({tag, " tx_start"}, bus.tx_start, 1);
    check_output({tag, " tx_data"}, bus.tx_data, exp_data);
    @(negedge clk);
    check_output({tag, " wait state"}, bus.estado, 5);
    check_output({tag, " start pulse width"}, bus.tx_start, 0);
    check_output({tag, " tx_data held"}, bus.tx_data, exp_data);
  endtask

  task automatic tx_ack(input string tag);
    @(negedge clk);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    check_output({tag, " back to op1"}, bus.estado, 0);
  endtask

  task automatic async_reset_check(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_output({tag, " op1"}, bus.operando_1, 0);
    check_output({tag, " op2"}, bus.operando_2, 0);
    check_output({tag, " opcode"}, bus.opcode, 0);
    check_output({tag, " tx_data"}, bus.tx_data, 0);
    check_output({tag, " estado"}, bus.estado, 0);
    check_output({tag, " tx_start"}, bus.tx_start, 0);
    #1 rst = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    start_count = 0;
    err_pulses  = 0;
    bus.rx_data = '0;
    bus.rx_done = 1'b0;
    bus.tx_done = 1'b0;
    rst         = 1'b1;
    idle(3);
    check_output("reset estado", bus.estado, 0);
    check_output("reset tx_data", bus.tx_data, 0);
    check_output("reset tx_start", bus.tx_start, 0);
    check_output("reset error", bus.error, 0);
    check_output("reset op1", bus.operando_1, 0);
    rst = 1'b0;
    idle(2);

    // ADD 5 + 3
    apply_stimulus(8'h05, 8'h03, 8'h08);
    check_output("add op1", bus.operando_1, 5);
    check_output("add op2", bus.operando_2, 3);
    check_output("add opcode", bus.opcode, 4'b1000);
    expect_tx("add", 8'h08);
    tx_ack("add");

    // SUB -2 - 1 with upper byte bits discarded
    apply_stimulus(8'hFE, 8'h01, 8'hFA);
    check_output("sub op1", bus.operando_1, 6'b111110);
    check_output("sub opcode", bus.opcode, 4'b1010);
    expect_tx("sub", 8'hFD);
    tx_ack("sub");

    // Timeout after operand 1
    send_byte(8'h05);
    idle(99);
    check_output("to pre error", bus.error, 0);
    check_output("to pre state", bus.estado, 1);
    idle(1);
    check_output("to error", bus.error, 1);
    check_output("to state", bus.estado, 0);
    check_output("to op2 kept", bus.operando_2, 1);
    idle(1);
    check_output("to error width", bus.error, 0);
    check_output("to pulse count", err_pulses, 1);
    apply_stimulus(8'h01, 8'h01, 8'h08);
    expect_tx("after to", 8'h02);
    tx_ack("after to");

    // Second byte lands exactly in the expiry cycle
    send_byte(8'h07);
    idle(98);
    send_byte(8'h02);
    check_output("bnd error", bus.error, 0);
    check_output("bnd state", bus.estado, 2);
    check_output("bnd op2", bus.operando_2, 2);
    send_byte(8'h08);
    check_output("bnd pulse count", err_pulses, 1);
    expect_tx("bnd", 8'h09);
    tx_ack("bnd");

    // Bytes arriving during ESPERA_TX are dropped
    apply_stimulus(8'h3C, 8'h0F, 8'h0C);
    expect_tx("and", 8'h0C);
    starts_before = start_count;
    @(negedge clk);
    bus.rx_data = 8'h33;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    check_output("drop state", bus.estado, 5);
    check_output("drop op1", bus.operando_1, 6'h3C);
    check_output("drop op2", bus.operando_2, 6'h0F);
    @(negedge clk);
    bus.rx_done = 1'b1;
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    bus.tx_done = 1'b0;
    check_output("drop+done state", bus.estado, 0);
    check_output("drop+done op1", bus.operando_1, 6'h3C);
    check_output("drop+done opcode", bus.opcode, 4'b1100);
    idle(3);
    check_output("drop no extra start", start_count, starts_before);
    apply_stimulus(8'h20, 8'h01, 8'h0E);
    check_output("xor op1", bus.operando_1, 6'h20);
    expect_tx("xor", 8'hE1);
    tx_ack("xor");

    // Asynchronous reset after two bytes
    send_byte(8'h07);
    idle(4);
    send_byte(8'h09);
    async_reset_check("rst mid");
    apply_stimulus(8'h0A, 8'h04, 8'h0A);
    expect_tx("rst mid cmd", 8'h06);
    tx_ack("rst mid cmd");

    // Asynchronous reset while waiting for the transmitter
    apply_stimulus(8'h02, 8'h03, 8'h08);
    expect_tx("pre rst tx", 8'h05);
    async_reset_check("rst tx");
    apply_stimulus(8'h3F, 8'h3F, 8'h08);
    expect_tx("rst tx cmd", 8'hFE);
    tx_ack("rst tx cmd");

    check_output("total error pulses", err_pulses, 1);
    check_output("total starts", start_count, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
